// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic light phase controller: major/minor lights plus per-road
// seconds-remaining countdowns, advanced by a 1 Hz tick enable.
module traffic_phase_ctrl #(
  parameter int MAJOR_GREEN = 40,
  parameter int MINOR_GREEN = 20,
  parameter int YELLOW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       minor_req,
  input  logic       emergency,
  output logic [5:0] major_countdown,
  output logic [5:0] minor_countdown,
  output logic [2:0] major_light,
  output logic [2:0] minor_light,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MG = 3'd0,
    MY = 3'd1,
    NG = 3'd2,
    NY = 3'd3,
    AR = 3'd4
  } state_t;

  localparam logic [5:0] T_MG  = 6'(MAJOR_GREEN);
  localparam logic [5:0] T_NG  = 6'(MINOR_GREEN);
  localparam logic [5:0] T_YEL = 6'(YELLOW);

  state_t     state, state_n;
  logic [5:0] t, t_n;
  logic       req_latch, req_latch_n;
  logic       expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MG;
      t         <= T_MG;
      req_latch <= 1'b0;
    end else begin
      state     <= state_n;
      t         <= t_n;
      req_latch <= req_latch_n;
    end
  end

  assign expire = tick_1hz && (t == 6'd1);

  always_comb begin
    state_n     = state;
    t_n         = t;
    req_latch_n = req_latch;
    if ((state == MG || state == MY) && minor_req)
      req_latch_n = 1'b1;
    if (emergency && state != AR) begin
      state_n = AR;
    end else begin
      case (state)
        AR: begin
          if (!emergency) begin
            state_n = MG;
            t_n     = T_MG;
          end
        end
        MG: begin
          if (expire) begin
            if (req_latch || minor_req) begin
              state_n = MY;
              t_n     = T_YEL;
            end else begin
              t_n = T_MG;
            end
          end else if (tick_1hz) begin
            t_n = t - 6'd1;
          end
        end
        MY: begin
          if (expire) begin
            state_n     = NG;
            t_n         = T_NG;
            // Serving the minor road consumes the request, even one arriving now.
            req_latch_n = 1'b0;
          end else if (tick_1hz) begin
            t_n = t - 6'd1;
          end
        end
        NG: begin
          if (expire) begin
            state_n = NY;
            t_n     = T_YEL;
          end else if (tick_1hz) begin
            t_n = t - 6'd1;
          end
        end
        NY: begin
          if (expire) begin
            state_n = MG;
            t_n     = T_MG;
          end else if (tick_1hz) begin
            t_n = t - 6'd1;
          end
        end
        default: begin
          state_n = AR;
        end
      endcase
    end
  end

  // The road not currently timing shows time until it next changes colour.
  always_comb begin
    major_light     = 3'b100;
    minor_light     = 3'b100;
    major_countdown = 6'd0;
    minor_countdown = 6'd0;
    case (state)
      MG: begin
        major_light     = 3'b001;
        major_countdown = t;
        minor_countdown = t + T_YEL;
      end
      MY: begin
        major_light     = 3'b010;
        major_countdown = t;
        minor_countdown = t;
      end
      NG: begin
        minor_light     = 3'b001;
        minor_countdown = t;
        major_countdown = t + T_YEL;
      end
      NY: begin
        minor_light     = 3'b010;
        major_countdown = t;
        minor_countdown = t;
      end
      default: begin
        major_light = 3'b100;
      end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with MAJOR_GREEN=5, MINOR_GREEN=3,
// YELLOW=2 and a tick every 10 clocks.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       minor_req = 1'b0;
  logic       emergency = 1'b0;
  logic [5:0] major_countdown, minor_countdown;
  logic [2:0] major_light, minor_light, phase;

  int errors = 0;
  int checks = 0;

  // Expected {phase, major count, minor count} after each tick.
  int pulse_ph[15] = '{0,0,1,1,2,2,2,3,3,0,0,0,0,0,0};
  int pulse_mc[15] = '{2,1,2,1,5,4,3,2,1,5,4,3,2,1,5};
  int pulse_nc[15] = '{4,3,2,1,3,2,1,2,1,7,6,5,4,3,7};
  int held_ph[29] = '{0,0,0,0,1,1,2,2,2,3,3,0,0,0,0,0,1,1,2,2,2,3,3,0,0,0,0,0,0};
  int held_mc[29] = '{4,3,2,1,2,1,5,4,3,2,1,5,4,3,2,1,2,1,5,4,3,2,1,5,4,3,2,1,5};
  int held_nc[29] = '{6,5,4,3,2,1,3,2,1,2,1,7,6,5,4,3,2,1,3,2,1,2,1,7,6,5,4,3,7};

  traffic_phase_ctrl #(
    .MAJOR_GREEN(5),
    .MINOR_GREEN(3),
    .YELLOW     (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tick_1hz       (tick_1hz),
    .minor_req      (minor_req),
    .emergency      (emergency),
    .major_countdown(major_countdown),
    .minor_countdown(minor_countdown),
    .major_light    (major_light),
    .minor_light    (minor_light),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] obs();
    return {phase, major_light, minor_light, major_countdown, minor_countdown};
  endfunction

  // Builds the expected output vector; lights follow from the phase alone.
  function automatic logic [20:0] expv(int ph, int mc, int nc);
    logic [2:0] ml, nl;
    case (ph)
      0:       begin ml = 3'b001; nl = 3'b100; end
      1:       begin ml = 3'b010; nl = 3'b100; end
      2:       begin ml = 3'b100; nl = 3'b001; end
      3:       begin ml = 3'b100; nl = 3'b010; end
      default: begin ml = 3'b100; nl = 3'b100; end
    endcase
    return {3'(ph), ml, nl, 6'(mc), 6'(nc)};
  endfunction

  task automatic tick_once();
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs() !== expv(0, 5, 7)) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs(), expv(0, 5, 7));
    end
  endtask

  task automatic test_no_req();
    for (int k = 1; k <= 12; k++) begin
      tick_once();
      checks++;
      if (obs() !== expv(0, 5 - (k % 5), 7 - (k % 5))) begin
        errors++;
        $display("FAIL no_req tick %0d: got %h expected %h", k, obs(),
                 expv(0, 5 - (k % 5), 7 - (k % 5)));
      end
    end
  endtask

  task automatic test_req_pulse();
    @(negedge clk) minor_req = 1'b1;
    @(negedge clk) minor_req = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick_once();
      checks++;
      if (obs() !== expv(pulse_ph[k], pulse_mc[k], pulse_nc[k])) begin
        errors++;
        $display("FAIL req_pulse tick %0d: got %h expected %h", k + 1, obs(),
                 expv(pulse_ph[k], pulse_mc[k], pulse_nc[k]));
      end
    end
  endtask

  task automatic test_req_held();
    @(negedge clk) minor_req = 1'b1;
    for (int k = 0; k < 29; k++) begin
      tick_once();
      if (k == 18) minor_req = 1'b0;
      checks++;
      if (obs() !== expv(held_ph[k], held_mc[k], held_nc[k])) begin
        errors++;
        $display("FAIL req_held tick %0d: got %h expected %h", k + 1, obs(),
                 expv(held_ph[k], held_mc[k], held_nc[k]));
      end
    end
  endtask

  task automatic test_emergency();
    @(negedge clk) minor_req = 1'b1;
    @(negedge clk) minor_req = 1'b0;
    repeat (8) tick_once();
    checks++;
    if (obs() !== expv(2, 4, 2)) begin
      errors++;
      $display("FAIL emerg_pre: got %h expected %h", obs(), expv(2, 4, 2));
    end
    emergency = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== expv(4, 0, 0)) begin
      errors++;
      $display("FAIL emerg_enter: got %h expected %h", obs(), expv(4, 0, 0));
    end
    for (int k = 1; k <= 3; k++) begin
      tick_once();
      checks++;
      if (obs() !== expv(4, 0, 0)) begin
        errors++;
        $display("FAIL emerg_hold %0d: got %h expected %h", k, obs(), expv(4, 0, 0));
      end
    end
    emergency = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== expv(0, 5, 7)) begin
      errors++;
      $display("FAIL emerg_release: got %h expected %h", obs(), expv(0, 5, 7));
    end
  endtask

  task automatic test_emerg_expiry();
    @(negedge clk) minor_req = 1'b1;
    @(negedge clk) minor_req = 1'b0;
    repeat (6) tick_once();
    checks++;
    if (obs() !== expv(1, 1, 1)) begin
      errors++;
      $display("FAIL ee_pre: got %h expected %h", obs(), expv(1, 1, 1));
    end
    @(negedge clk) begin tick_1hz = 1'b1; emergency = 1'b1; end
    @(negedge clk) tick_1hz = 1'b0;
    checks++;
    if (obs() !== expv(4, 0, 0)) begin
      errors++;
      $display("FAIL ee_enter: got %h expected %h", obs(), expv(4, 0, 0));
    end
    repeat (5) @(negedge clk);
    checks++;
    if (obs() !== expv(4, 0, 0)) begin
      errors++;
      $display("FAIL ee_hold: got %h expected %h", obs(), expv(4, 0, 0));
    end
    emergency = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== expv(0, 5, 7)) begin
      errors++;
      $display("FAIL ee_release: got %h expected %h", obs(), expv(0, 5, 7));
    end
    repeat (4) tick_once();
    checks++;
    if (obs() !== expv(0, 1, 3)) begin
      errors++;
      $display("FAIL ee_mg_last: got %h expected %h", obs(), expv(0, 1, 3));
    end
    tick_once();
    checks++;
    if (obs() !== expv(1, 2, 2)) begin
      errors++;
      $display("FAIL ee_latch_kept: got %h expected %h", obs(), expv(1, 2, 2));
    end
  endtask

  task automatic test_rst_mid();
    repeat (5) tick_once();
    checks++;
    if (obs() !== expv(3, 2, 2)) begin
      errors++;
      $display("FAIL rst_pre: got %h expected %h", obs(), expv(3, 2, 2));
    end
    @(negedge clk) begin rst = 1'b1; tick_1hz = 1'b1; emergency = 1'b1; end
    @(negedge clk) begin rst = 1'b0; tick_1hz = 1'b0; emergency = 1'b0; end
    checks++;
    if (obs() !== expv(0, 5, 7)) begin
      errors++;
      $display("FAIL rst_mid: got %h expected %h", obs(), expv(0, 5, 7));
    end
    repeat (4) tick_once();
    checks++;
    if (obs() !== expv(0, 1, 3)) begin
      errors++;
      $display("FAIL rst_count: got %h expected %h", obs(), expv(0, 1, 3));
    end
    tick_once();
    checks++;
    if (obs() !== expv(0, 5, 7)) begin
      errors++;
      $display("FAIL rst_latch_clr: got %h expected %h", obs(), expv(0, 5, 7));
    end
  endtask

  initial begin
    test_reset();
    test_no_req();
    test_req_pulse();
    test_req_held();
    test_emergency();
    test_emerg_expiry();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
